// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit beside the EX-stage ALU: owns HI/LO, runs
// MULT/MULTU/DIV/DIVU over 32 cycles, serves MFHI/MFLO/MTHI/MTLO, and stalls the pipe.
module mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rrs,
    input  logic [31:0] rrt,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rslt
);

    localparam logic [5:0] INST_R  = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, rslt_q, rslt_d;
    logic [31:0] a_q, a_d, b_q, b_d, rs_q, rs_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d, is_div_q, is_div_d;

    logic        mdu_op, accept, op_signed;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic [63:0] prod_fixed;

    assign mdu_op    = valid && (opcode == INST_R) &&
                       (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                      F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign busy      = (state_q != S_IDLE);
    assign stall     = mdu_op && busy;
    assign accept    = mdu_op && !busy;
    assign rslt      = rslt_q;

    // |0x80000000| stays 0x80000000 and is treated as unsigned from here on.
    assign op_signed = (funct == F_MULT) || (funct == F_DIV);
    assign rs_mag    = (op_signed && rrs[31]) ? (~rrs + 32'd1) : rrs;
    assign rt_mag    = (op_signed && rrt[31]) ? (~rrt + 32'd1) : rrt;

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    assign mul_sum    = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    // Divide: acc_q[32:0] is the partial remainder, a_q shifts dividend out / quotient in.
    assign div_shift  = {acc_q[31:0], a_q[31]};
    assign div_trial  = {1'b0, div_shift} - {2'b00, b_q};
    assign prod_fixed = neg_res_q ? (~acc_q + 64'd1) : acc_q;

    // NOTE: every variable written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rslt_d    = rslt_q;
        a_d       = a_q;
        b_d       = b_q;
        rs_d      = rs_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (funct)
                        F_MTHI: hi_d   = rrs;
                        F_MTLO: lo_d   = rrs;
                        F_MFHI: rslt_d = hi_q;
                        F_MFLO: rslt_d = lo_q;
                        default: begin
                            state_d   = (funct == F_DIV || funct == F_DIVU) ? S_DIV : S_MUL;
                            is_div_d  = (funct == F_DIV || funct == F_DIVU);
                            cnt_d     = 5'd0;
                            a_d       = rs_mag;
                            b_d       = rt_mag;
                            rs_d      = rrs;
                            acc_d     = 64'd0;
                            neg_res_d = op_signed && (rrs[31] ^ rrt[31]);
                            neg_rem_d = op_signed && rrs[31];
                            div0_d    = (rrt == 32'd0);
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                b_d   = {1'b0, b_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_trial[33]) begin
                    acc_d = {31'd0, div_trial[32:0]};
                    a_d   = {a_q[30:0], 1'b1};
                end else begin
                    acc_d = {31'd0, div_shift};
                    a_d   = {a_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    hi_d = prod_fixed[63:32];
                    lo_d = prod_fixed[31:0];
                end else if (div0_q) begin
                    hi_d = rs_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = neg_rem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
                    lo_d = neg_res_q ? (~a_q + 32'd1) : a_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            rslt_q    <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rs_q      <= 32'd0;
            acc_q     <= 64'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rslt_q    <= rslt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rs_q      <= rs_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
        end
    end

endmodule
